// File: rtl/mac_sequencer_if.sv
// Request/memory/result bundle for the MAC sequencer.
// master = requester plus memory side, slave = the sequencer.
interface mac_sequencer_if #(
  parameter int n         = 8,
  parameter int k         = 8,
  parameter int b         = 8,
  parameter int MAXLEN    = 16,
  parameter int AW        = (MAXLEN > 1) ? $clog2(MAXLEN) : 1,
  parameter int LW        = $clog2(MAXLEN + 1),
  parameter int res_width = n + k + $clog2(MAXLEN) + 1
);
  logic                        start;
  logic [LW-1:0]               len;
  logic signed [b-1:0]         bias;
  logic                        abort;
  logic                        rd_en;
  logic [AW-1:0]               addr;
  logic signed [k-1:0]         act_data;
  logic signed [n-1:0]         wgt_data;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [res_width-1:0] result;

  modport master (
    output start, len, bias, abort, act_data, wgt_data, out_ready,
    input  rd_en, addr, busy, out_valid, result
  );

  modport slave (
    input  start, len, bias, abort, act_data, wgt_data, out_ready,
    output rd_en, addr, busy, out_valid, result
  );
endinterface

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams len addresses to the activation/weight
// memories, accumulates signed products onto a bias, and holds the result
// until the consumer takes it. Parameters must match the bound interface.
module mac_sequencer #(
  parameter int n         = 8,
  parameter int k         = 8,
  parameter int b         = 8,
  parameter int MAXLEN    = 16,
  parameter int AW        = (MAXLEN > 1) ? $clog2(MAXLEN) : 1,
  parameter int LW        = $clog2(MAXLEN + 1),
  parameter int res_width = n + k + $clog2(MAXLEN) + 1
) (
  input logic           clk,
  input logic           rst,
  mac_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                      state, state_nxt;
  logic [LW-1:0]               len_q, len_clamp;
  logic [AW-1:0]               addr_q;
  logic                        rd_q, rd_d;
  logic signed [res_width-1:0] acc;
  logic signed [n+k-1:0]       prod;
  logic                        last_rd;

  assign len_clamp = (bus.len > LW'(MAXLEN)) ? LW'(MAXLEN) : bus.len;
  // AW never exceeds LW, so widening addr to LW+1 bits is lossless
  assign last_rd   = ((LW+1)'(addr_q) + (LW+1)'(1)) == {1'b0, len_q};
  assign prod      = (n+k)'(bus.act_data) * (n+k)'(bus.wgt_data);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (len_clamp == '0) ? DONE : READ;
      READ:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && (state != IDLE)) state_nxt = IDLE;
  end

  // outputs: status decoded from state, strobe/address/result from flops
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.rd_en     = rd_q;
    bus.addr      = addr_q;
    bus.result    = acc;
  end

  // datapath: read strobe, address walk, data-qualify delay, accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= 1'b0;
      rd_d   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      acc    <= '0;
    end else begin
      rd_q <= (state_nxt == READ);
      rd_d <= rd_q;
      if ((state == IDLE) && bus.start) begin
        len_q <= len_clamp;
        acc   <= res_width'(bus.bias);
        // only move addr when a read burst actually follows
        if (len_clamp != '0) addr_q <= '0;
      end
      // advance only while staying in READ so addr holds once rd_en drops
      if ((state == READ) && (state_nxt == READ)) addr_q <= addr_q + AW'(1);
      // data lags rd_en by one cycle; gate on state so aborted reads are dropped
      if (rd_d && ((state == READ) || (state == DRAIN)))
        acc <= acc + res_width'(prod);
    end
  end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter n, default 8: weight width in bits, signed.
REQ-002 Parameter k, default 8: activation width in bits, signed.
REQ-003 Parameter b, default 8: bias width in bits, signed.
REQ-004 Parameter MAXLEN, default 16: maximum dot-product length, integer >= 1.
REQ-005 Parameter AW, default $clog2(MAXLEN) (minimum 1): memory address width.
REQ-006 Parameter LW, default $clog2(MAXLEN+1): length field width.
REQ-007 Parameter res_width, default n+k+$clog2(MAXLEN)+1: accumulator and result width; must be >= b.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 start  input  1  request a new dot product; sampled only in IDLE.
REQ-011 len  input  LW  element count, latched with start; values > MAXLEN clamped to MAXLEN.
REQ-012 bias  input  b  signed initial accumulator value, latched with start.
REQ-013 abort  input  1  synchronous cancel of the current operation.
REQ-014 rd_en  output  1  registered read strobe to activation and weight memories.
REQ-015 addr  output  AW  registered read address, shared by both memories.
REQ-016 act_data  input  k  signed activation, valid the cycle after the rd_en cycle that requested it.
REQ-017 wgt_data  input  n  signed weight, same timing as act_data.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 out_valid  output  1  result is valid; held until accepted.
REQ-020 out_ready  input  1  consumer accepts result when high with out_valid.
REQ-021 result  output  res_width  signed dot product plus bias.

Function
REQ-022 FSM states: IDLE, READ, DRAIN, DONE.
REQ-023 IDLE with start=1, len>0: latch clamped len; acc <= sign-extended bias; next cycle rd_en=1, addr=0; go to READ.
REQ-024 IDLE with start=1, len=0: acc <= sign-extended bias; go directly to DONE; no rd_en pulse.
REQ-025 READ: rd_en high for exactly len consecutive cycles; addr 0,1,...,len-1; last read cycle transitions to DRAIN.
REQ-026 A one-cycle-delayed copy of rd_en qualifies data; on each qualified cycle acc <= acc + act_data*wgt_data, full-precision signed product sign-extended to res_width.
REQ-027 DRAIN: one cycle, final product accumulated; then DONE with out_valid=1 and result=acc.
REQ-028 Latency: start sampled in cycle 0 -> rd_en in cycles 1..len -> out_valid first high in cycle len+2.
REQ-029 DONE: result and out_valid stable until out_valid&out_ready; next cycle out_valid=0, state IDLE.
REQ-030 start while busy=1 is ignored, including in the cycle of the out_valid/out_ready handshake.
REQ-031 Accumulation wraps modulo 2^res_width (two's complement); no saturation, no overflow flag.
REQ-032 abort=1 in any non-IDLE state: next cycle IDLE; rd_en, out_valid = 0; any result discarded; abort in IDLE has no effect.
REQ-033 abort and out_ready simultaneously in DONE: abort wins (result counts as discarded).
REQ-034 addr holds its last value when rd_en=0; addr is never out of range 0..MAXLEN-1.

Reset
REQ-035 rst=1 at a clock edge: state IDLE; rd_en=0, addr=0, busy=0, out_valid=0, result=0, acc=0; takes priority over start and abort.
REQ-036 rst asserted mid-operation aborts with no further rd_en and no out_valid; the first start after rst deasserts is honoured normally.

Verification
REQ-037 len=4, bias=5, act={1,2,3,4}, wgt={10,-1,2,3}: rd_en cycles 1-4, addr 0-3 -> out_valid in cycle 6, result=5+10-2+6+12=31.
REQ-038 len=0, bias=-7 -> no rd_en, out_valid next cycle, result=-7 (sign-extended).
REQ-039 len=MAXLEN=16, all act=-128, all wgt=-128, bias=127 -> result=16*16384+127=262271; len=20 -> clamped to identical behaviour.
REQ-040 out_ready held low 10 cycles after out_valid, start pulsed during wait -> result stable, start ignored, IDLE one cycle after out_ready.
REQ-041 abort in cycle 2 of a len=8 run -> rd_en low and busy low from cycle 3, no out_valid; a following len=1 run (act=3, wgt=3, bias=0) gives result=9.
REQ-042 rst asserted in cycle 3 of a len=8 run, together with start -> all outputs zero next cycle, start ignored, no out_valid.
